bias_dac_loader: RTL



---
 rtl/bias_dac_pkg.sv | 34 +++
 rtl/bias_bit_timer.sv | 33 +++
 rtl/bias_dac_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bias_dac_pkg.sv
// bias_dac_pkg
// Shared types and helpers for the bias DAC serial loader.
//   state_t       : loader FSM states
//   PARITY_BITS   : 1 when BIAS_PARITY_EN is defined, else 0
//   frame_width() : bits per serial frame (address + data [+ parity])
//   next_enabled(): lowest enabled channel index >= from, or num_ch if none
// Optional feature macro: BIAS_PARITY_EN (trailing even-parity bit per frame).
package bias_dac_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam int MAX_CH = 32;

`ifdef BIAS_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_width(input int addr_w, input int data_w);
    return addr_w + data_w + PARITY_BITS;
  endfunction

  // Scan high to low so the last hit is the lowest qualifying index.
  function automatic int next_enabled(input logic [MAX_CH-1:0] mask,
                                      input int from, input int num_ch);
    int res;
    res = num_ch;
    for (int i = MAX_CH - 1; i >= 0; i--)
      if (i >= from && i < num_ch && mask[i]) res = i;
    return res;
  endfunction

endpackage

// File: rtl/bias_bit_timer.sv
// bias_bit_timer
// Bit-period divider: 2*CLK_DIV clk cycles per bit period.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the divider
//   clr        : synchronous clear back to the start of a bit period
//   sclk_lvl   : low for the first CLK_DIV cycles, high for the last CLK_DIV
//   bit_start  : first cycle of a bit period (while enabled)
//   bit_end    : last cycle of a bit period (while enabled)
module bias_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk_lvl,
  output logic bit_start,
  output logic bit_end
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(2 * CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)  div <= '0;
    else if (en)        div <= (div == LAST) ? '0 : div + DW'(1);
  end

  assign sclk_lvl  = (div >= DW'(CLK_DIV));
  assign bit_start = en && (div == '0);
  assign bit_end   = en && (div == LAST);
endmodule

// File: rtl/bias_dac_loader.sv
// bias_dac_loader
// Snapshots NUM_CH bias words on start and shifts one CS-framed word
// (address MSB first, then data MSB first) per enabled channel, with an
// idle gap of GAP_BITS bit periods between frames.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load request, only honoured in IDLE
//   ch_mask    : per-channel enable, sampled with start
//   bias_data  : channel i at [i*DATA_W +: DATA_W], sampled with start
//   busy       : frames or gaps in progress
//   done       : one-cycle pulse at load completion
//   sclk/sda/cs_n : DAC serial pins; sclk idles low, cs_n active low
//   cur_ch     : channel being shifted, 0 when idle
// Optional feature macro: BIAS_PARITY_EN adds a trailing even-parity bit.
module bias_dac_loader
  import bias_dac_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] bias_data,
  output logic                     busy,
  output logic                     done,
  output logic                     sclk,
  output logic                     sda,
  output logic                     cs_n,
  output logic [ADDR_W-1:0]        cur_ch
);
  localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
  localparam int BW      = $clog2(FRAME_W + 1);
  localparam int GW      = $clog2(GAP_BITS + 1);

  state_t                     state, state_nx;
  logic [NUM_CH-1:0]          snap_mask;
  logic [NUM_CH*DATA_W-1:0]   snap_data;
  logic [FRAME_W-1:0]         sr;
  logic [BW-1:0]              bit_cnt;
  logic [GW-1:0]              gap_cnt;
  logic [ADDR_W-1:0]          ch;
  logic                       sclk_lvl, bit_start, bit_end, tmr_en;
  logic                       frame_last, gap_last;
  int                         first_ch, nxt_ch, sel;
  logic [MAX_CH-1:0]          m_in, m_snap;
  logic [DATA_W-1:0]          sel_data;
  logic [FRAME_W-1:0]         load_word;

  assign tmr_en = (state == SHIFT) || (state == GAP);

  bias_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tmr_en),
    .clr      (!tmr_en),
    .sclk_lvl (sclk_lvl),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  // Counters count bit-period starts, so the terminal value equals the length.
  assign frame_last = (state == SHIFT) && bit_end && (bit_cnt == BW'(FRAME_W));
  assign gap_last   = (state == GAP)   && bit_end && (gap_cnt == GW'(GAP_BITS));

  // Channel selection and frame word for the next frame to be loaded.
  // From IDLE the live inputs are used (snapshot cycle); afterwards the snapshot.
  always_comb begin
    m_in   = '0;
    m_snap = '0;
    m_in[NUM_CH-1:0]   = ch_mask;
    m_snap[NUM_CH-1:0] = snap_mask;
    first_ch = next_enabled(m_in, 0, NUM_CH);
    nxt_ch   = next_enabled(m_snap, int'(ch) + 1, NUM_CH);
    sel      = (state == IDLE) ? first_ch : nxt_ch;
    if (sel >= NUM_CH) sel = 0;
    sel_data = (state == IDLE) ? bias_data[sel*DATA_W +: DATA_W]
                               : snap_data[sel*DATA_W +: DATA_W];
`ifdef BIAS_PARITY_EN
    load_word = {ADDR_W'(sel), sel_data, ^{ADDR_W'(sel), sel_data}};
`else
    load_word = {ADDR_W'(sel), sel_data};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (first_ch < NUM_CH) ? SHIFT : DONE;
      SHIFT: begin
        busy = 1'b1;
        if (frame_last) state_nx = (nxt_ch < NUM_CH) ? GAP : DONE;
      end
      GAP: begin
        busy = 1'b1;
        if (gap_last) state_nx = SHIFT;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_mask <= '0;
      snap_data <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ch        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap_mask <= ch_mask;
          snap_data <= bias_data;
          ch        <= ADDR_W'(first_ch);
          sr        <= load_word;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          if (bit_start) bit_cnt <= bit_cnt + BW'(1);
          if (bit_end)   sr <= sr << 1;
          if (frame_last) gap_cnt <= '0;
        end
        GAP: begin
          if (bit_start) gap_cnt <= gap_cnt + GW'(1);
          if (gap_last) begin
            ch      <= ADDR_W'(nxt_ch);
            sr      <= load_word;
            bit_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cs_n   = (state != SHIFT);
  assign sclk   = (state == SHIFT) && sclk_lvl;
  assign sda    = (state == SHIFT) && sr[FRAME_W-1];
  assign cur_ch = tmr_en ? ch : '0;
endmodule
